// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM states
// and the one-hot helper used by both the picker and the grant register.
package arb_pkg;

    localparam int N        = 8;
    localparam int IDXW     = 3;
    localparam int MAX_HOLD = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo 8, with one optional index excluded from the search.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    input  logic       mask_en,
    input  logic [2:0] mask_idx,
    output logic [2:0] idx,
    output logic       found
);

    logic [7:0]  req_m;
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  enc;

    always_comb begin
        req_m = req;
        if (mask_en) begin
            req_m = req & ~onehot(mask_idx);
        end

        // rot[j] holds req_m[(ptr + j) mod 8], so index 0 is the current pointer
        dbl = {req_m, req_m} >> ptr;
        rot = dbl[7:0];

        enc   = 3'd0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                enc   = 3'(i);
                found = 1'b1;
            end
        end

        // 3-bit add wraps naturally back into the unrotated index space
        idx = enc + ptr;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot/index grant
// and a hold-limit timeout that forces preemption of a long-running holder.
//
//   state | meaning
//   IDLE  | no holder; any request is granted at the next edge
//   GRANT | one holder owns the resource until release or timeout
module rr_arbiter8 #(
    parameter int N        = arb_pkg::N,
    parameter int IDXW     = arb_pkg::IDXW,
    parameter int MAX_HOLD = arb_pkg::MAX_HOLD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);
    import arb_pkg::*;

    localparam int HCW = $clog2(MAX_HOLD) + 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

    state_t          state, state_nxt;
    logic [IDXW-1:0] ptr, ptr_nxt;
    logic [HCW-1:0]  hold_cnt, hold_nxt;
    logic [N-1:0]    gnt_nxt;
    logic [IDXW-1:0] idx_nxt;
    logic            valid_nxt;
    logic            timeout_nxt;

    logic [IDXW-1:0] pick_ptr;
    logic [IDXW-1:0] pick_idx;
    logic            pick_found;
    logic            holder_req;
    logic            hold_expired;

    // While granted, the search starts just past the holder and skips it
    assign pick_ptr     = (state == GRANT) ? IDXW'(gnt_idx + 1'b1) : ptr;
    assign holder_req   = req[gnt_idx];
    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    rr_pick8 u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .mask_en  (state == GRANT),
        .mask_idx (gnt_idx),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        gnt_nxt     = gnt;
        idx_nxt     = gnt_idx;
        valid_nxt   = gnt_valid;
        timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt   = onehot(pick_idx);
                    idx_nxt   = pick_idx;
                    valid_nxt = 1'b1;
                    hold_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!holder_req) begin
                    ptr_nxt = pick_ptr;
                    if (pick_found) begin
                        gnt_nxt  = onehot(pick_idx);
                        idx_nxt  = pick_idx;
                        hold_nxt = '0;
                    end else begin
                        gnt_nxt   = '0;
                        idx_nxt   = '0;
                        valid_nxt = 1'b0;
                        hold_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end else if (hold_expired) begin
                    // With no other requester the holder simply keeps the grant
                    timeout_nxt = 1'b1;
                    ptr_nxt     = pick_ptr;
                    hold_nxt    = '0;
                    if (pick_found) begin
                        gnt_nxt = onehot(pick_idx);
                        idx_nxt = pick_idx;
                    end
                end else if (hold_cnt != {HCW{1'b1}}) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                idx_nxt   = '0;
                valid_nxt = 1'b0;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and random checks for rr_arbiter8 with a hold limit of 4 cycles.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int passed = 0;
    int total  = 0;

    rr_arbiter8 #(.N(8), .IDXW(3), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        logic [7:0] one_at;
        @(posedge clk);
        #1;
        one_at = 8'd1 << gnt_idx;
        chk("inv_onehot", 32'((gnt & (gnt - 8'd1)) == 8'd0), 32'd1);
        chk("inv_valid", 32'(gnt_valid), 32'(gnt != 8'd0));
        if (gnt_valid) chk("inv_idx", 32'(gnt), 32'(one_at));
        else           chk("inv_idle_idx", 32'(gnt_idx), 32'd0);
    endtask

    task automatic expect_gnt(input string tag, input logic [7:0] g, input logic [2:0] i,
                              input logic v, input logic t);
        chk({tag, "_gnt"}, 32'(gnt), 32'(g));
        chk({tag, "_idx"}, 32'(gnt_idx), 32'(i));
        chk({tag, "_valid"}, 32'(gnt_valid), 32'(v));
        chk({tag, "_timeout"}, 32'(timeout), 32'(t));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
    endtask

    int         waits [8];
    int         hold_left [8];
    logic [7:0] prev_req;
    logic [7:0] prev_gnt;
    logic [7:0] r;
    logic       new_grant;

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        #12;
        expect_gnt("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Grant, then asynchronous reset mid-cycle
        req = 8'hFF;
        step();
        expect_gnt("first", 8'h01, 3'd0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        expect_gnt("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        step();
        expect_gnt("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);
        do_reset();

        // Basic grant, back-to-back handover, release to idle
        req = 8'b0000_0101;
        step();
        expect_gnt("basic0", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'b0000_0100;
        step();
        expect_gnt("basic2", 8'h04, 3'd2, 1'b1, 1'b0);
        req = 8'h00;
        step();
        expect_gnt("basic_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Wrap-around: ptr is now 3, so requester 7 wins, then 0, then 1
        req = 8'b1000_0000;
        step();
        expect_gnt("wrap7", 8'h80, 3'd7, 1'b1, 1'b0);
        req = 8'b0000_0011;
        step();
        expect_gnt("wrap0", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'b0000_0010;
        step();
        expect_gnt("wrap1", 8'h02, 3'd1, 1'b1, 1'b0);
        req = 8'h00;
        step();
        expect_gnt("wrap_idle", 8'h00, 3'd0, 1'b0, 1'b0);
        do_reset();

        // Timeout preemption between requesters 0 and 7
        req = 8'b1000_0001;
        step();
        expect_gnt("to_g0", 8'h01, 3'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            expect_gnt("to_hold0", 8'h01, 3'd0, 1'b1, 1'b0);
        end
        step();
        expect_gnt("to_pre7", 8'h80, 3'd7, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            expect_gnt("to_hold7", 8'h80, 3'd7, 1'b1, 1'b0);
        end
        step();
        expect_gnt("to_pre0", 8'h01, 3'd0, 1'b1, 1'b1);

        // Holder 0 releases; sole requester 4 keeps being re-granted
        req = 8'b0001_0000;
        step();
        expect_gnt("sole_g4", 8'h10, 3'd4, 1'b1, 1'b0);
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 3; k++) begin
                step();
                expect_gnt("sole_hold", 8'h10, 3'd4, 1'b1, 1'b0);
            end
            step();
            expect_gnt("sole_regrant", 8'h10, 3'd4, 1'b1, 1'b1);
        end

        // Release on the same edge the hold limit expires: release wins, no pulse
        for (int k = 0; k < 3; k++) begin
            step();
            expect_gnt("sim_hold", 8'h10, 3'd4, 1'b1, 1'b0);
        end
        req = 8'h00;
        step();
        expect_gnt("sim_release", 8'h00, 3'd0, 1'b0, 1'b0);
        do_reset();

        // Random traffic: holders release after 1-20 cycles of ownership
        for (int i = 0; i < 8; i++) begin
            waits[i]     = 0;
            hold_left[i] = 0;
        end
        prev_gnt = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            prev_req = req;
            step();
            new_grant = gnt_valid && ((gnt != prev_gnt) || timeout);
            for (int i = 0; i < 8; i++) begin
                if (gnt[i]) begin
                    waits[i] = 0;
                end else if (!prev_req[i]) begin
                    waits[i] = 0;
                end else if (new_grant) begin
                    waits[i]++;
                    chk("fair_wait", 32'(waits[i] <= 7), 32'd1);
                end
            end
            prev_gnt = gnt;
            r = req;
            for (int i = 0; i < 8; i++) begin
                if (gnt[i] && r[i]) begin
                    if (hold_left[i] == 0) hold_left[i] = $urandom_range(1, 20);
                    hold_left[i]--;
                    if (hold_left[i] == 0) r[i] = 1'b0;
                end else if (!r[i] && !gnt[i]) begin
                    if ($urandom_range(0, 3) == 0) r[i] = 1'b1;
                end
            end
            req = r;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
